vec_wb_sequencer: RTL and testbench
===================================

Name: vec_wb_sequencer

Overview:
- Sits between the EX/MEM pipeline register and the vector register file (VRF) write ports.
- Captures one 8-lane vector writeback (VRegWrite + lane results) per instruction.
- Drains it over LANES/WR_PORTS cycles through the VRF's limited write ports.
- Stalls the pipeline only when a second vector writeback arrives before the drain ends; exports pending-write info to the hazard unit.

Parameters:
- LANES, 8, vector lanes per instruction (power of 2).
- DATA_W, 32, bits per lane.
- ADDR_W, 5, vector register index width.
- WR_PORTS, 2, VRF write ports per cycle (power of 2, divides LANES); BEATS = LANES/WR_PORTS.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- vwb_valid_i  in  1  vector writeback request (EX/MEM VRegWrite_o); held by upstream while stall_o=1.
- vwb_addr_i  in  ADDR_W  destination vector register.
- vwb_data_i  in  LANES*DATA_W  lane results; lane0 in bits [DATA_W-1:0].
- stall_o  out  1  freeze EX/MEM and earlier stages (combinational).
- vrf_we_o  in/out: out  WR_PORTS  per-port write enable.
- vrf_addr_o  out  ADDR_W  vector register being written (shared by all ports).
- vrf_lane_o  out  WR_PORTS*log2(LANES)  lane index per port.
- vrf_wdata_o  out  WR_PORTS*DATA_W  write data per port.
- busy_o  out  1  drain in progress.
- pend_valid_o  out  1  a captured writeback is not yet fully written.
- pend_addr_o  out  ADDR_W  register with pending writes (hazard unit compares sources).
- done_o  out  1  one-cycle pulse on the final beat of an instruction.

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, beat=0; all outputs 0; capture registers cleared.
- Reset mid-drain aborts the instruction: no further writes, and the partial write is not completed.
- FSM IDLE:
  - vwb_valid_i=1 → capture addr/data, beat=0, go DRAIN.
  - stall_o=0 in IDLE; the request is accepted the same cycle it arrives.
- FSM DRAIN, each cycle:
  - Port k writes lane beat*WR_PORTS+k from the captured data; vrf_we_o all 1.
  - vrf_addr_o = captured addr.
  - beat increments by 1.
- Last beat (beat=BEATS-1):
  - done_o=1.
  - If vwb_valid_i=1: capture the new instruction, beat=0, stay DRAIN (back-to-back, no bubble).
  - Otherwise go IDLE.
- stall_o = vwb_valid_i & (state=DRAIN) & (beat≠BEATS-1).
- Latency: first VRF write one cycle after acceptance; final write BEATS cycles after acceptance (default 4).
- Throughput: one vector instruction per BEATS cycles.
- vrf_we_o=0 in IDLE; vrf_addr_o, vrf_lane_o and vrf_wdata_o are 0 in IDLE.
- busy_o = (state=DRAIN).
- pend_valid_o = busy_o; pend_addr_o = captured addr while busy, else 0.
- Inputs present while stall_o=1 are not sampled; upstream must hold them stable.
- WR_PORTS=LANES (BEATS=1): every cycle in DRAIN is a last beat; stall_o is never asserted.

Optional Feature:
- Macro VWB_LANE_MASK_EN.
- Defined:
  - Adds input vwb_mask_i [LANES], captured with the data.
  - vrf_we_o[k] = captured mask bit of the lane driven by port k.
  - Beat count and timing are unchanged; an all-zero mask still takes BEATS cycles and pulses done_o.
- Not defined: port absent; all lanes always written.

Test Plan:
- Reset, then single request: vwb_valid_i=1 for 1 cycle, addr=5, lane i = 0x1000+i.
  - Cycles 1-4 write lanes {0,1},{2,3},{4,5},{6,7} to addr 5.
  - done_o on cycle 4; busy_o=0 on cycle 5; stall_o stays 0.
- Back-to-back: second request (addr=9) held from cycle 2 of the first drain.
  - stall_o=1 on cycles 2-3; accepted on cycle 4.
  - addr 9 writes on cycles 5-8 with no idle gap.
- Request arriving exactly on the last beat → stall_o=0 that cycle; next drain starts the following cycle.
- rst_n=0 during beat 1 → no vrf_we_o afterwards; all outputs 0 the cycle after reset; a later request drains normally.
- Hazard: during drain of addr=3, pend_valid_o=1 and pend_addr_o=3 on every beat; both 0 after completion.
- With VWB_LANE_MASK_EN, mask=8'b1010_0101 → writes only lanes 0,2,5,7; done_o still on beat 4.

Source files
------------

// File: rtl/vec_wb_sequencer_if.sv
// vec_wb_sequencer_if: writeback request and VRF write-port bundle for vec_wb_sequencer.
// Request side: vwb_valid_i, vwb_addr_i, vwb_data_i (+ vwb_mask_i with VWB_LANE_MASK_EN), stall_o.
// VRF side: vrf_we_o, vrf_addr_o, vrf_lane_o, vrf_wdata_o.
// Status: busy_o, pend_valid_o, pend_addr_o, done_o.
// master = upstream pipeline / VRF environment, slave = the sequencer.
interface vec_wb_sequencer_if #(
    parameter int LANES    = 8,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int WR_PORTS = 2
);
    localparam int LW = $clog2(LANES);
    logic                       vwb_valid_i;
    logic [ADDR_W-1:0]          vwb_addr_i;
    logic [LANES*DATA_W-1:0]    vwb_data_i;
`ifdef VWB_LANE_MASK_EN
    logic [LANES-1:0]           vwb_mask_i;
`endif
    logic                       stall_o;
    logic [WR_PORTS-1:0]        vrf_we_o;
    logic [ADDR_W-1:0]          vrf_addr_o;
    logic [WR_PORTS*LW-1:0]     vrf_lane_o;
    logic [WR_PORTS*DATA_W-1:0] vrf_wdata_o;
    logic                       busy_o;
    logic                       pend_valid_o;
    logic [ADDR_W-1:0]          pend_addr_o;
    logic                       done_o;
`ifdef VWB_LANE_MASK_EN
    modport master (output vwb_valid_i, vwb_addr_i, vwb_data_i, vwb_mask_i,
                    input stall_o, vrf_we_o, vrf_addr_o, vrf_lane_o, vrf_wdata_o,
                    busy_o, pend_valid_o, pend_addr_o, done_o);
    modport slave (input vwb_valid_i, vwb_addr_i, vwb_data_i, vwb_mask_i,
                   output stall_o, vrf_we_o, vrf_addr_o, vrf_lane_o, vrf_wdata_o,
                   busy_o, pend_valid_o, pend_addr_o, done_o);
`else
    modport master (output vwb_valid_i, vwb_addr_i, vwb_data_i,
                    input stall_o, vrf_we_o, vrf_addr_o, vrf_lane_o, vrf_wdata_o,
                    busy_o, pend_valid_o, pend_addr_o, done_o);
    modport slave (input vwb_valid_i, vwb_addr_i, vwb_data_i,
                   output stall_o, vrf_we_o, vrf_addr_o, vrf_lane_o, vrf_wdata_o,
                   busy_o, pend_valid_o, pend_addr_o, done_o);
`endif
endinterface

// File: rtl/vec_wb_sequencer.sv
// vec_wb_sequencer: captures one vector writeback and drains it through WR_PORTS VRF write ports over BEATS cycles.
// Ports: clk, rst_n (sync, active-low), bus (vec_wb_sequencer_if.slave: request, VRF write, hazard/status signals).
// Optional: define VWB_LANE_MASK_EN to add a per-lane write mask captured with the data.
module vec_wb_sequencer #(
    parameter int LANES    = 8,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int WR_PORTS = 2
) (
    input logic               clk,
    input logic               rst_n,
    vec_wb_sequencer_if.slave bus
);
    localparam int BEATS = LANES / WR_PORTS;
    localparam int LW    = $clog2(LANES);
    localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                  state, state_nx;
    logic [BW-1:0]           beat;
    logic [ADDR_W-1:0]       cap_addr;
    logic [LANES*DATA_W-1:0] cap_data;
    logic [LANES-1:0]        cap_mask;
    logic                    last;
    logic                    accept;

    // A new request is taken when idle or on the final beat, giving back-to-back drains.
    assign last   = state == DRAIN && beat == BW'(BEATS - 1);
    assign accept = bus.vwb_valid_i && (state == IDLE || last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat     <= '0;
            cap_addr <= '0;
            cap_data <= '0;
            cap_mask <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                beat     <= '0;
                cap_addr <= bus.vwb_addr_i;
                cap_data <= bus.vwb_data_i;
`ifdef VWB_LANE_MASK_EN
                cap_mask <= bus.vwb_mask_i;
`else
                cap_mask <= '1;
`endif
            end else if (state == DRAIN) begin
                beat <= last ? '0 : beat + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = accept ? DRAIN : (last ? IDLE : state);
    end

    always_comb begin
        bus.stall_o      = bus.vwb_valid_i && state == DRAIN && !last;
        bus.busy_o       = state == DRAIN;
        bus.pend_valid_o = state == DRAIN;
        bus.pend_addr_o  = state == DRAIN ? cap_addr : '0;
        bus.vrf_addr_o   = state == DRAIN ? cap_addr : '0;
        bus.done_o       = last;
        bus.vrf_we_o     = '0;
        bus.vrf_lane_o   = '0;
        bus.vrf_wdata_o  = '0;
        for (int k = 0; k < WR_PORTS; k++) begin
            if (state == DRAIN) begin
                bus.vrf_we_o[k]                    = cap_mask[int'(beat) * WR_PORTS + k];
                bus.vrf_lane_o[k*LW +: LW]         = LW'(int'(beat) * WR_PORTS + k);
                bus.vrf_wdata_o[k*DATA_W +: DATA_W] = cap_data[(int'(beat) * WR_PORTS + k) * DATA_W +: DATA_W];
            end
        end
    end
endmodule

// File: tb/tb_vec_wb_sequencer.sv
// tb_vec_wb_sequencer: directed scoreboard bench for vec_wb_sequencer (default parameters).
module tb_vec_wb_sequencer;
    typedef struct {
        logic [4:0]  addr;
        logic [5:0]  lane;
        logic [63:0] wdata;
        logic [1:0]  we;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    int    n_tests = 0;
    int    n_fail = 0;
    beat_t q[$];

    vec_wb_sequencer_if bus ();
    vec_wb_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk(input logic [31:0] base);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = base + 32'(i);
        return r;
    endfunction

    task automatic drive(input logic v, input logic [4:0] a, input logic [255:0] d, input logic [7:0] m);
        bus.vwb_valid_i = v;
        bus.vwb_addr_i  = a;
        bus.vwb_data_i  = d;
`ifdef VWB_LANE_MASK_EN
        bus.vwb_mask_i  = m;
`endif
    endtask

    task automatic push_req(input logic [4:0] a, input logic [255:0] d, input logic [7:0] m);
        beat_t e;
        for (int b = 0; b < 4; b++) begin
            e.addr = a;
            for (int k = 0; k < 2; k++) begin
                e.lane[k*3 +: 3]   = 3'(b * 2 + k);
                e.wdata[k*32 +: 32] = d[(b*2+k)*32 +: 32];
                e.we[k]            = m[b*2+k];
            end
            q.push_back(e);
        end
    endtask

    // Every drain cycle consumes one expected beat; idle cycles must not write.
    always @(negedge clk) begin
        beat_t e;
        #2;
        if (bus.busy_o === 1'b1) begin
            n_tests++;
            assert (q.size() > 0) else begin
                n_fail++;
                $error("FAIL sb_underflow: observed write to %0h with empty scoreboard", bus.vrf_addr_o);
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("wr_addr", bus.vrf_addr_o, e.addr);
                chk("wr_lane", bus.vrf_lane_o, e.lane);
                chk("wr_data", bus.vrf_wdata_o, e.wdata);
                chk("wr_we", bus.vrf_we_o, e.we);
            end
        end else begin
            chk("idle_we", bus.vrf_we_o, 0);
        end
    end

    initial begin
        drive(0, 0, '0, 8'hFF);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", bus.stall_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_pend", {bus.pend_valid_o, bus.pend_addr_o}, 0);
        chk("rst_vrf", {bus.vrf_we_o, bus.vrf_addr_o, bus.vrf_lane_o}, 0);
        chk("rst_wdata", bus.vrf_wdata_o, 0);
        rst_n = 1'b1;

        // single request, addr 5
        @(negedge clk);
        drive(1, 5, mk(32'h1000), 8'hFF);
        push_req(5, mk(32'h1000), 8'hFF);
        #1;
        chk("t1_accept_stall", bus.stall_o, 0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            drive(0, 0, '0, 8'hFF);
            #1;
            chk("t1_stall", bus.stall_o, 0);
            chk("t1_busy", bus.busy_o, c <= 4);
            chk("t1_done", bus.done_o, c == 4);
            chk("t1_pend_addr", bus.pend_addr_o, c <= 4 ? 5 : 0);
        end

        // back-to-back: addr 3, then addr 9 held from cycle 2
        @(negedge clk);
        drive(1, 3, mk(32'h2000), 8'hFF);
        push_req(3, mk(32'h2000), 8'hFF);
        #1;
        chk("t2_accept_stall", bus.stall_o, 0);
        @(negedge clk);
        drive(0, 0, '0, 8'hFF);
        #1;
        chk("t2_pend_valid", bus.pend_valid_o, 1);
        chk("t2_pend_addr_c1", bus.pend_addr_o, 3);
        @(negedge clk);
        drive(1, 9, mk(32'h3000), 8'hFF);
        push_req(9, mk(32'h3000), 8'hFF);
        #1;
        chk("t2_stall_c2", bus.stall_o, 1);
        chk("t2_pend_addr_c2", bus.pend_addr_o, 3);
        @(negedge clk);
        #1;
        chk("t2_stall_c3", bus.stall_o, 1);
        chk("t2_pend_addr_c3", bus.pend_addr_o, 3);
        @(negedge clk);
        #1;
        chk("t2_stall_c4", bus.stall_o, 0);
        chk("t2_done_c4", bus.done_o, 1);
        chk("t2_pend_addr_c4", bus.pend_addr_o, 3);
        @(negedge clk);
        drive(0, 0, '0, 8'hFF);
        #1;
        chk("t2_busy_c5", bus.busy_o, 1);
        chk("t2_pend_addr_c5", bus.pend_addr_o, 9);
        chk("t2_done_c5", bus.done_o, 0);
        repeat (2) @(negedge clk);
        @(negedge clk);
        #1;
        chk("t2_done_c8", bus.done_o, 1);
        @(negedge clk);
        #1;
        chk("t2_pend_after", {bus.pend_valid_o, bus.pend_addr_o}, 0);
        chk("t2_busy_after", bus.busy_o, 0);

        // request arriving exactly on the last beat
        @(negedge clk);
        drive(1, 12, mk(32'h4000), 8'hFF);
        push_req(12, mk(32'h4000), 8'hFF);
        @(negedge clk);
        drive(0, 0, '0, 8'hFF);
        repeat (3) @(negedge clk);
        drive(1, 17, mk(32'h5000), 8'hFF);
        push_req(17, mk(32'h5000), 8'hFF);
        #1;
        chk("t3_stall_last", bus.stall_o, 0);
        chk("t3_done_last", bus.done_o, 1);
        @(negedge clk);
        drive(0, 0, '0, 8'hFF);
        #1;
        chk("t3_busy_next", bus.busy_o, 1);
        chk("t3_pend_next", bus.pend_addr_o, 17);
        repeat (2) @(negedge clk);
        @(negedge clk);
        #1;
        chk("t3_done", bus.done_o, 1);
        @(negedge clk);
        #1;
        chk("t3_idle", bus.busy_o, 0);

        // reset during beat 1 aborts the drain
        @(negedge clk);
        drive(1, 20, mk(32'h6000), 8'hFF);
        push_req(20, mk(32'h6000), 8'hFF);
        @(negedge clk);
        drive(0, 0, '0, 8'hFF);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("t4_rst_busy", bus.busy_o, 0);
        chk("t4_rst_we", bus.vrf_we_o, 0);
        chk("t4_rst_done", bus.done_o, 0);
        chk("t4_rst_pend", {bus.pend_valid_o, bus.pend_addr_o}, 0);
        chk("t4_rst_vrf", {bus.vrf_addr_o, bus.vrf_lane_o}, 0);
        chk("t4_rst_wdata", bus.vrf_wdata_o, 0);
        q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("t4_no_we", bus.vrf_we_o, 0);
        @(negedge clk);
        drive(1, 22, mk(32'h7000), 8'hFF);
        push_req(22, mk(32'h7000), 8'hFF);
        @(negedge clk);
        drive(0, 0, '0, 8'hFF);
        repeat (2) @(negedge clk);
        @(negedge clk);
        #1;
        chk("t4_done", bus.done_o, 1);
        @(negedge clk);
        #1;
        chk("t4_idle", bus.busy_o, 0);

`ifdef VWB_LANE_MASK_EN
        // masked writes: lanes 0,2,5,7 only
        @(negedge clk);
        drive(1, 30, mk(32'h8000), 8'b1010_0101);
        push_req(30, mk(32'h8000), 8'b1010_0101);
        @(negedge clk);
        drive(0, 0, '0, 8'hFF);
        #1;
        chk("t5_we_b0", bus.vrf_we_o, 2'b01);
        repeat (2) @(negedge clk);
        @(negedge clk);
        #1;
        chk("t5_done", bus.done_o, 1);
        @(negedge clk);
        drive(1, 31, mk(32'h9000), 8'h00);
        push_req(31, mk(32'h9000), 8'h00);
        @(negedge clk);
        drive(0, 0, '0, 8'hFF);
        repeat (2) @(negedge clk);
        @(negedge clk);
        #1;
        chk("t5_zero_mask_done", bus.done_o, 1);
        @(negedge clk);
`endif

        repeat (2) @(negedge clk);
        #3;
        chk("sb_empty", 64'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
